// File: rtl/mega_regs_mp_pkg.sv
// Shared definitions for the mega register file:
// pointer codes, pointer pair bases and FSM states.
package xmega_v;

  typedef enum logic [1:0] {
    PTR_NONE = 2'd0,
    PTR_X    = 2'd1,
    PTR_Y    = 2'd2,
    PTR_Z    = 2'd3
  } ptr_e;

  localparam logic [3:0] PAIR_X = 4'd13;
  localparam logic [3:0] PAIR_Y = 4'd14;
  localparam logic [3:0] PAIR_Z = 4'd15;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  function automatic logic [3:0] ptr_pair(input logic [1:0] p);
    logic [3:0] r;
    case (ptr_e'(p))
      PTR_X:   r = PAIR_X;
      PTR_Y:   r = PAIR_Y;
      PTR_Z:   r = PAIR_Z;
      default: r = 4'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mega_regs_mp_bank.sv
// One 8-bit register bank: two async read ports,
// a main write port and a pointer write lane.
module mega_regs_bank #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk_i,
  input  logic [AW-1:0] ra1_i,
  input  logic [AW-1:0] ra2_i,
  output logic [7:0]    rd1_o,
  output logic [7:0]    rd2_o,
  input  logic          we_i,
  input  logic [AW-1:0] wa_i,
  input  logic [7:0]    wd_i,
  input  logic          pe_i,
  input  logic [AW-1:0] pa_i,
  input  logic [7:0]    pd_i
);

  logic [7:0] mem_q [DEPTH];

  // Top guarantees the two lanes never hit the same entry
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[wa_i] <= wd_i;
    if (pe_i) mem_q[pa_i] <= pd_i;
  end

  assign rd1_o = mem_q[ra1_i];
  assign rd2_o = mem_q[ra2_i];

endmodule

// File: rtl/mega_regs_mp.sv
// Byte register file with word-pair access, pointer
// write port, forwarding and a post-reset clear sequence.
module mega_regs_mp
  import xmega_v::*;
#(
  parameter int    REG_COUNT          = 32,
  parameter string REGISTERED_OUTPUTS = "FALSE",
  parameter string BYPASS             = "TRUE",
  parameter string CLEAR_ON_RESET     = "TRUE"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1a,
  input  logic        rs1m,
  output logic [15:0] rs1,
  input  logic [4:0]  rs2a,
  input  logic        rs2m,
  output logic [15:0] rs2,
  input  logic [4:0]  rda,
  input  logic [15:0] rd,
  input  logic        rdw,
  input  logic        rdm,
  input  logic [1:0]  pwa,
  input  logic [15:0] pwd,
  input  logic        pww,
  output logic        busy
);

  localparam int DEPTH = REG_COUNT / 2;
  localparam int AW    = $clog2(DEPTH);
  localparam bit LIM16 = (REG_COUNT == 16);
  localparam bit REGO  = (REGISTERED_OUTPUTS == "TRUE");
  localparam bit BYP   = (BYPASS == "TRUE");
  localparam bit CLR   = (CLEAR_ON_RESET == "TRUE");
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  // With 16 registers only pairs 8..15 exist
  function automatic logic pair_ok(input logic [3:0] p);
    return !LIM16 || p[3];
  endfunction

  function automatic logic [15:0] read_mux(
    input logic       a0,
    input logic       m,
    input logic [7:0] lo,
    input logic [7:0] hi
  );
    if (m) return {hi, lo};
    return {8'h00, a0 ? hi : lo};
  endfunction

  state_e        state_q;
  logic [AW-1:0] cnt_q;
  logic          clr;
  logic          wr_ok;

  assign clr   = (state_q == ST_CLEAR);
  assign wr_ok = (state_q == ST_RUN) & ~rst;

  // Clear sequencer: zero one pair per cycle, then hold RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLR ? ST_CLEAR : ST_RUN;
      cnt_q   <= '0;
    end else if (state_q == ST_CLEAR) begin
      if (cnt_q == LAST) state_q <= ST_RUN;
      else cnt_q <= cnt_q + AW'(1);
    end
  end

  logic [3:0] d_pair;
  logic [3:0] p_pair;
  logic       d_lo;
  logic       d_hi;
  logic       p_hit;
  logic       p_lo;
  logic       p_hi;
  logic [7:0] d_lo_dat;
  logic [7:0] d_hi_dat;

  assign d_pair   = rdm ? rda[3:0] : rda[4:1];
  assign d_lo     = wr_ok & rdw & pair_ok(d_pair)
                  & (rdm | ~rda[0]);
  assign d_hi     = wr_ok & rdw & pair_ok(d_pair)
                  & (rdm | rda[0]);
  assign d_lo_dat = rd[7:0];
  assign d_hi_dat = rdm ? rd[15:8] : rd[7:0];

  assign p_pair = ptr_pair(pwa);
  assign p_hit  = wr_ok & pww & (pwa != 2'd0)
                & pair_ok(p_pair);
  // Port D owns any byte it also writes
  assign p_lo   = p_hit & ~(d_lo & (d_pair == p_pair));
  assign p_hi   = p_hit & ~(d_hi & (d_pair == p_pair));

  logic [3:0]    r1_pair;
  logic [3:0]    r2_pair;
  logic [7:0]    lo1, lo2, hi1, hi2;
  logic          lo_we, hi_we;
  logic [AW-1:0] lo_wa, hi_wa;
  logic [7:0]    lo_wd, hi_wd;

  assign r1_pair = rs1m ? rs1a[3:0] : rs1a[4:1];
  assign r2_pair = rs2m ? rs2a[3:0] : rs2a[4:1];

  assign lo_we = clr | d_lo;
  assign hi_we = clr | d_hi;
  assign lo_wa = clr ? cnt_q : d_pair[AW-1:0];
  assign hi_wa = clr ? cnt_q : d_pair[AW-1:0];
  assign lo_wd = clr ? 8'h00 : d_lo_dat;
  assign hi_wd = clr ? 8'h00 : d_hi_dat;

  mega_regs_bank #(.DEPTH(DEPTH), .AW(AW)) u_lo (
    .clk_i (clk),
    .ra1_i (r1_pair[AW-1:0]),
    .ra2_i (r2_pair[AW-1:0]),
    .rd1_o (lo1),
    .rd2_o (lo2),
    .we_i  (lo_we),
    .wa_i  (lo_wa),
    .wd_i  (lo_wd),
    .pe_i  (p_lo),
    .pa_i  (p_pair[AW-1:0]),
    .pd_i  (pwd[7:0])
  );

  mega_regs_bank #(.DEPTH(DEPTH), .AW(AW)) u_hi (
    .clk_i (clk),
    .ra1_i (r1_pair[AW-1:0]),
    .ra2_i (r2_pair[AW-1:0]),
    .rd1_o (hi1),
    .rd2_o (hi2),
    .we_i  (hi_we),
    .wa_i  (hi_wa),
    .wd_i  (hi_wd),
    .pe_i  (p_hi),
    .pa_i  (p_pair[AW-1:0]),
    .pd_i  (pwd[15:8])
  );

  logic [7:0]  f1_lo, f1_hi, f2_lo, f2_hi;
  logic [15:0] rs1_d, rs2_d;
  logic [15:0] rs1_q, rs2_q;

  // Forward in-flight bytes (D over P), then form read data
  always_comb begin
    f1_lo = lo1;
    f1_hi = hi1;
    f2_lo = lo2;
    f2_hi = hi2;
    if (BYP) begin
      if (p_lo && p_pair == r1_pair) f1_lo = pwd[7:0];
      if (p_hi && p_pair == r1_pair) f1_hi = pwd[15:8];
      if (p_lo && p_pair == r2_pair) f2_lo = pwd[7:0];
      if (p_hi && p_pair == r2_pair) f2_hi = pwd[15:8];
      if (d_lo && d_pair == r1_pair) f1_lo = d_lo_dat;
      if (d_hi && d_pair == r1_pair) f1_hi = d_hi_dat;
      if (d_lo && d_pair == r2_pair) f2_lo = d_lo_dat;
      if (d_hi && d_pair == r2_pair) f2_hi = d_hi_dat;
    end
    rs1_d = '0;
    rs2_d = '0;
    if (!clr && pair_ok(r1_pair))
      rs1_d = read_mux(rs1a[0], rs1m, f1_lo, f1_hi);
    if (!clr && pair_ok(r2_pair))
      rs2_d = read_mux(rs2a[0], rs2m, f2_lo, f2_hi);
  end

  // Optional one-cycle read stage
  always_ff @(posedge clk) begin
    if (rst) begin
      rs1_q <= '0;
      rs2_q <= '0;
    end else begin
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
    end
  end

  assign rs1  = rst ? 16'h0000 : (REGO ? rs1_q : rs1_d);
  assign rs2  = rst ? 16'h0000 : (REGO ? rs2_q : rs2_d);
  assign busy = rst ? CLR : clr;

endmodule

// File: tb/tb_mega_regs_mp.sv
// Bench for mega_regs_mp: four configurations share one
// stimulus stream and are checked against array models.
module tb_mega_regs_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1a, rs2a, rda;
  logic        rs1m, rs2m, rdw, rdm, pww;
  logic [15:0] rd, pwd;
  logic [1:0]  pwa;

  logic [15:0] a_rs1, a_rs2, b_rs1, b_rs2;
  logic [15:0] c_rs1, c_rs2, d_rs1, d_rs2;
  logic        a_busy, b_busy, c_busy, d_busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] m32 [32];
  logic [7:0] n32 [32];
  logic [7:0] m16 [32];
  logic [7:0] n16 [32];

  always #5 clk = ~clk;

  mega_regs_mp u_a (
    .clk(clk), .rst(rst),
    .rs1a(rs1a), .rs1m(rs1m), .rs1(a_rs1),
    .rs2a(rs2a), .rs2m(rs2m), .rs2(a_rs2),
    .rda(rda), .rd(rd), .rdw(rdw), .rdm(rdm),
    .pwa(pwa), .pwd(pwd), .pww(pww), .busy(a_busy)
  );

  mega_regs_mp #(.BYPASS("FALSE")) u_b (
    .clk(clk), .rst(rst),
    .rs1a(rs1a), .rs1m(rs1m), .rs1(b_rs1),
    .rs2a(rs2a), .rs2m(rs2m), .rs2(b_rs2),
    .rda(rda), .rd(rd), .rdw(rdw), .rdm(rdm),
    .pwa(pwa), .pwd(pwd), .pww(pww), .busy(b_busy)
  );

  mega_regs_mp #(
    .REG_COUNT(16), .REGISTERED_OUTPUTS("TRUE")
  ) u_c (
    .clk(clk), .rst(rst),
    .rs1a(rs1a), .rs1m(rs1m), .rs1(c_rs1),
    .rs2a(rs2a), .rs2m(rs2m), .rs2(c_rs2),
    .rda(rda), .rd(rd), .rdw(rdw), .rdm(rdm),
    .pwa(pwa), .pwd(pwd), .pww(pww), .busy(c_busy)
  );

  mega_regs_mp #(.CLEAR_ON_RESET("FALSE")) u_d (
    .clk(clk), .rst(rst),
    .rs1a(rs1a), .rs1m(rs1m), .rs1(d_rs1),
    .rs2a(rs2a), .rs2m(rs2m), .rs2(d_rs2),
    .rda(rda), .rd(rd), .rdw(rdw), .rdm(rdm),
    .pwa(pwa), .pwd(pwd), .pww(pww), .busy(d_busy)
  );

  // Contents after this cycle's writes: P first, D overrides
  function automatic void calc_next();
    for (int i = 0; i < 32; i++) begin
      n32[i] = m32[i];
      n16[i] = m16[i];
    end
    if (pww && pwa != 2'd0) begin
      n32[2 * (12 + pwa)]     = pwd[7:0];
      n32[2 * (12 + pwa) + 1] = pwd[15:8];
    end
    if (rdw) begin
      if (rdm) begin
        n32[2 * rda[3:0]]     = rd[7:0];
        n32[2 * rda[3:0] + 1] = rd[15:8];
      end else begin
        n32[rda] = rd[7:0];
      end
    end
    for (int i = 16; i < 32; i++) n16[i] = n32[i] == m32[i]
                                        ? m16[i] : n32[i];
  endfunction

  function automatic logic [7:0] byte_of(
    input int i, input bit nx, input bit lim);
    if (lim && i < 16) return 8'h00;
    if (lim) return nx ? n16[i] : m16[i];
    return nx ? n32[i] : m32[i];
  endfunction

  function automatic logic [15:0] rd_ref(
    input logic [4:0] a, input logic m,
    input bit nx, input bit lim);
    int n;
    if (m) begin
      n = int'(a[3:0]);
      return {byte_of(2 * n + 1, nx, lim),
              byte_of(2 * n, nx, lim)};
    end
    return {8'h00, byte_of(int'(a), nx, lim)};
  endfunction

  task automatic step();
    calc_next();
    @(posedge clk);
    for (int i = 0; i < 32; i++) begin
      m32[i] = n32[i];
      m16[i] = n16[i];
    end
    #1;
  endtask

  task automatic idle();
    rdw = 0; rdm = 0; rda = 0; rd = 0;
    pww = 0; pwa = 0; pwd = 0;
  endtask

  task automatic test_reset();
    int ca, cc, cd;
    idle();
    rs1a = 0; rs1m = 0; rs2a = 0; rs2m = 0;
    rst = 1;
    @(negedge clk);
    checks++;
    if (a_busy !== 1'b1 || d_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy a=%b d=%b want 1/0", a_busy, d_busy);
    end
    checks++;
    if (a_rs1 !== 16'h0 || c_rs2 !== 16'h0) begin
      errors++;
      $display("FAIL rst_out a=%h c=%h want 0", a_rs1, c_rs2);
    end
    @(posedge clk); #1;
    rst = 0;
    ca = 0; cc = 0; cd = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (a_busy) ca++;
      if (c_busy) cc++;
      if (d_busy) cd++;
      @(posedge clk); #1;
    end
    checks++;
    if (ca != 16) begin
      errors++;
      $display("FAIL busy32 got %0d want 16", ca);
    end
    checks++;
    if (cc != 8) begin
      errors++;
      $display("FAIL busy16 got %0d want 8", cc);
    end
    checks++;
    if (cd != 0) begin
      errors++;
      $display("FAIL busy_noclr got %0d want 0", cd);
    end
    for (int i = 0; i < 32; i++) begin
      rs1a = 5'(i);
      #1;
      checks++;
      if (a_rs1 !== 16'h0) begin
        errors++;
        $display("FAIL clr_r%0d got %h want 0000", i, a_rs1);
      end
    end
    for (int i = 0; i < 32; i++) begin
      m32[i] = 8'h00;
      m16[i] = 8'h00;
    end
  endtask

  task automatic test_restart();
    int ca;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    ca = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (a_busy) ca++;
      @(posedge clk); #1;
    end
    checks++;
    if (ca != 16) begin
      errors++;
      $display("FAIL restart_busy got %0d want 16", ca);
    end
  endtask

  task automatic test_word_write();
    rdw = 1; rdm = 1; rda = 13; rd = 16'hA55A;
    step();
    idle();
    rs1m = 1; rs1a = 13; rs2m = 0; rs2a = 27;
    #1;
    checks++;
    if (a_rs1 !== 16'hA55A) begin
      errors++;
      $display("FAIL word_rd got %h want a55a", a_rs1);
    end
    checks++;
    if (a_rs2 !== 16'h00A5) begin
      errors++;
      $display("FAIL word_hi got %h want 00a5", a_rs2);
    end
  endtask

  task automatic test_dp_collide();
    rdw = 1; rdm = 0; rda = 26; rd = 16'h0011;
    pww = 1; pwa = 1; pwd = 16'h2233;
    step();
    idle();
    rs1m = 1; rs1a = 13;
    #1;
    checks++;
    if (a_rs1 !== 16'h2211 || b_rs1 !== 16'h2211) begin
      errors++;
      $display("FAIL dp_prio a=%h b=%h want 2211", a_rs1, b_rs1);
    end
  endtask

  task automatic test_bypass();
    rdw = 1; rdm = 0; rda = 5; rd = 16'h0033;
    step();
    rd = 16'h007E; rs1m = 0; rs1a = 5;
    #1;
    checks++;
    if (a_rs1 !== 16'h007E) begin
      errors++;
      $display("FAIL byp_on got %h want 007e", a_rs1);
    end
    checks++;
    if (b_rs1 !== 16'h0033) begin
      errors++;
      $display("FAIL byp_off got %h want 0033", b_rs1);
    end
    step();
    rda = 26; rd = 16'h0044;
    pww = 1; pwa = 1; pwd = 16'hBEEF;
    rs2m = 1; rs2a = 13;
    #1;
    checks++;
    if (a_rs2 !== 16'hBE44 || b_rs2 !== 16'h2211) begin
      errors++;
      $display("FAIL byp_dp a=%h b=%h want be44/2211",
               a_rs2, b_rs2);
    end
    step();
    idle();
    #1;
    checks++;
    if (b_rs2 !== 16'hBE44) begin
      errors++;
      $display("FAIL byp_after got %h want be44", b_rs2);
    end
  endtask

  task automatic test_r16();
    rdw = 1; rdm = 0; rda = 3; rd = 16'h00FF;
    rs1m = 0; rs1a = 3; rs2m = 0; rs2a = 21;
    step();
    rda = 20;
    step();
    idle();
    rs2a = 20;
    #1;
    checks++;
    if (c_rs1 !== 16'h0 || c_rs2 !== 16'h0) begin
      errors++;
      $display("FAIL r16_lat r1=%h r2=%h want 0/0", c_rs1, c_rs2);
    end
    step();
    checks++;
    if (c_rs2 !== 16'h00FF) begin
      errors++;
      $display("FAIL r16_r20 got %h want 00ff", c_rs2);
    end
    checks++;
    if (c_rs1 !== 16'h0 || a_rs1 !== 16'h00FF) begin
      errors++;
      $display("FAIL r16_r3 c=%h a=%h want 0000/00ff",
               c_rs1, a_rs1);
    end
  endtask

  task automatic test_random();
    logic [15:0] e1, e2, p1, p2;
    p1 = 0; p2 = 0;
    for (int k = 0; k < 300; k++) begin
      rdw = 1'($urandom); rdm = 1'($urandom);
      rda = 5'($urandom); rd = 16'($urandom);
      pww = 1'($urandom); pwa = 2'($urandom);
      pwd = 16'($urandom);
      rs1m = 1'($urandom); rs2m = 1'($urandom);
      rs1a = $urandom_range(0, 1) ? rda : 5'($urandom);
      rs2a = $urandom_range(0, 1) ? {3'b110, pwa}
                                  : 5'($urandom);
      calc_next();
      @(negedge clk);
      e1 = rd_ref(rs1a, rs1m, 1, 0);
      e2 = rd_ref(rs2a, rs2m, 1, 0);
      checks++;
      if (a_rs1 !== e1 || a_rs2 !== e2) begin
        errors++;
        $display("FAIL rnd_byp k=%0d got %h/%h want %h/%h",
                 k, a_rs1, a_rs2, e1, e2);
      end
      e1 = rd_ref(rs1a, rs1m, 0, 0);
      e2 = rd_ref(rs2a, rs2m, 0, 0);
      checks++;
      if (b_rs1 !== e1 || b_rs2 !== e2) begin
        errors++;
        $display("FAIL rnd_old k=%0d got %h/%h want %h/%h",
                 k, b_rs1, b_rs2, e1, e2);
      end
      if (k > 0) begin
        checks++;
        if (c_rs1 !== p1 || c_rs2 !== p2) begin
          errors++;
          $display("FAIL rnd_r16 k=%0d got %h/%h want %h/%h",
                   k, c_rs1, c_rs2, p1, p2);
        end
      end
      p1 = rd_ref(rs1a, rs1m, 1, 1);
      p2 = rd_ref(rs2a, rs2m, 1, 1);
      step();
    end
    idle();
  endtask

  task automatic test_noclear();
    rdw = 1; rdm = 1; rda = 10; rd = 16'h1234;
    step();
    idle();
    rs1m = 1; rs1a = 10;
    rst = 1;
    #1;
    checks++;
    if (d_busy !== 1'b0 || a_busy !== 1'b1) begin
      errors++;
      $display("FAIL noclr_busy d=%b a=%b want 0/1", d_busy, a_busy);
    end
    checks++;
    if (d_rs1 !== 16'h0) begin
      errors++;
      $display("FAIL noclr_rst got %h want 0000", d_rs1);
    end
    @(posedge clk); #1;
    rst = 0;
    #1;
    checks++;
    if (d_rs1 !== 16'h1234 || d_busy !== 1'b0) begin
      errors++;
      $display("FAIL noclr_keep got %h busy=%b want 1234/0",
               d_rs1, d_busy);
    end
  endtask

  initial begin
    test_reset();
    test_restart();
    test_word_write();
    test_dp_collide();
    test_bypass();
    test_r16();
    test_random();
    test_noclear();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
